// File: rtl/neuron_mac_sequencer.sv
// Drives the shared 3-op ALU (ADD/MUL/SLT) to evaluate one neuron:
// a wrapped dot product of input/weight pairs, then a signed threshold compare.
module neuron_mac_sequencer #(
  parameter int nBits   = 32,
  parameter int LenBits = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LenBits-1:0] len,
  input  logic [nBits-1:0]   threshold,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [nBits-1:0]   in_x,
  input  logic [nBits-1:0]   in_w,
  output logic [2:0]         ALUControl,
  output logic [nBits-1:0]   SrcA,
  output logic [nBits-1:0]   SrcB,
  input  logic [nBits-1:0]   ALUResult,
  output logic               busy,
  output logic               done,
  output logic [nBits-1:0]   sum_out,
  output logic               fire
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_ACT   = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;

  logic [2:0]         state_q, state_d;
  logic [nBits-1:0]   acc_q, acc_d;
  logic [nBits-1:0]   prod_q, prod_d;
  logic [nBits-1:0]   x_q, x_d;
  logic [nBits-1:0]   w_q, w_d;
  logic [nBits-1:0]   thr_q, thr_d;
  logic [LenBits-1:0] cnt_q, cnt_d;
  logic [LenBits-1:0] len_q, len_d;
  logic [nBits-1:0]   sum_q, sum_d;
  logic               fire_q, fire_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    x_d     = x_q;
    w_d     = w_q;
    thr_d   = thr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    fire_d  = fire_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          len_d   = len;
          thr_d   = threshold;
          state_d = (len != '0) ? S_FETCH : S_ACT;
        end
      end
      S_FETCH: begin
        if (in_valid) begin
          x_d     = in_x;
          w_d     = in_w;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d  = ALUResult;
        state_d = S_ADD;
      end
      S_ADD: begin
        acc_d   = ALUResult;
        cnt_d   = cnt_q + LenBits'(1);
        state_d = (cnt_q == len_q - LenBits'(1)) ? S_ACT : S_FETCH;
      end
      S_ACT: begin
        // SLT(thr, acc) yields 1 exactly when threshold < sum
        sum_d   = acc_q;
        fire_d  = ALUResult[0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive depends only on registered state, never on inputs
  always_comb begin
    ALUControl = OP_ADD;
    SrcA       = '0;
    SrcB       = '0;
    case (state_q)
      S_MUL: begin
        ALUControl = OP_MUL;
        SrcA       = x_q;
        SrcB       = w_q;
      end
      S_ADD: begin
        ALUControl = OP_ADD;
        SrcA       = acc_q;
        SrcB       = prod_q;
      end
      S_ACT: begin
        ALUControl = OP_SLT;
        SrcA       = thr_q;
        SrcB       = acc_q;
      end
      default: begin
        ALUControl = OP_ADD;
        SrcA       = '0;
        SrcB       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      prod_q  <= '0;
      x_q     <= '0;
      w_q     <= '0;
      thr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      fire_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      x_q     <= x_d;
      w_q     <= w_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      fire_q  <= fire_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == S_FETCH);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign fire     = fire_q;

endmodule
